// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO; optional sticky errors via SYNC_FIFO_ERR_EN
module sync_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DWIDTH-1:0]          wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [DWIDTH-1:0]          rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic                       err_clr,
    output logic                       ovf_err,
    output logic                       udf_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              wr_accept;
    logic              rd_accept;

    // Flags come only from registered pointers, never from wr_en/rd_en.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count     = wr_ptr_q - rd_ptr_q;
        wr_accept = wr_en && !full;
        rd_accept = rd_en && !empty;
        wr_ptr_d  = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = rd_accept ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        rd_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;

    // A new rejected request outranks a clear in the same cycle.
    always_comb begin
        ovf_err_d = (wr_en && full)  || (ovf_err_q && !err_clr);
        udf_err_d = (rd_en && empty) || (udf_err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed bench for sync_fifo
module tb_sync_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        empty;
    logic [3:0]  count;
`ifdef SYNC_FIFO_ERR_EN
    logic        err_clr;
    logic        ovf_err;
    logic        udf_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo #(.DWIDTH(32), .DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .count   (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr (err_clr),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_empty(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"}, 32'(full), 32'd0);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".rd_data"}, rd_data, 32'd0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        step(); step();
        chk_idle_empty("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle_empty("idle");
`ifdef SYNC_FIFO_ERR_EN
            chk("idle.ovf_err", 32'(ovf_err), 32'd0);
            chk("idle.udf_err", 32'(udf_err), 32'd0);
`endif
        end

        // Fill 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 32'((i + 1) * 'h11);
            step();
            chk("fill.count", 32'(count), 32'(i + 1));
            chk("fill.head", rd_data, 32'h11);
        end
        wr_en = 1'b0;
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.empty", 32'(empty), 32'd0);

        for (int i = 0; i < 8; i++) begin
            chk("drain.data", rd_data, 32'((i + 1) * 'h11));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk_idle_empty("drained");

        // Pointers at 8; push/pop 6 then push 6 more to cross the wrap
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 32'(i + 1);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("pre_wrap.data", rd_data, 32'(i + 1));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 32'('hA0 + i);
            step();
        end
        wr_en = 1'b0;
        chk("wrap.count", 32'(count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("wrap.data", rd_data, 32'('hA0 + i));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk_idle_empty("wrap_done");

        // Simultaneous push/pop at count=3
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 32'('h31 + i);
            step();
        end
        wr_data = 32'h55; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("mid_both.count", 32'(count), 32'd3);
        chk("mid_both.head", rd_data, 32'h32);
        begin
            logic [31:0] exp_mid [3];
            exp_mid[0] = 32'h32; exp_mid[1] = 32'h33; exp_mid[2] = 32'h55;
            for (int i = 0; i < 3; i++) begin
                chk("mid_both.data", rd_data, exp_mid[i]);
                rd_en = 1'b1;
                step();
            end
        end
        rd_en = 1'b0;
        chk_idle_empty("mid_done");

        // Simultaneous push/pop at full: push dropped
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 32'('hB0 + i);
            step();
        end
        chk("full_both.pre_full", 32'(full), 32'd1);
        wr_data = 32'h99; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("full_both.count", 32'(count), 32'd7);
        chk("full_both.head", rd_data, 32'hB1);
`ifdef SYNC_FIFO_ERR_EN
        chk("full_both.ovf_err", 32'(ovf_err), 32'd1);
        chk("full_both.udf_err", 32'(udf_err), 32'd0);
`endif
        for (int i = 1; i < 8; i++) begin
            chk("full_both.data", rd_data, 32'('hB0 + i));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk_idle_empty("full_both_done");

        // Simultaneous push/pop at empty: pop ignored
        wr_en = 1'b1; wr_data = 32'h77; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("empty_both.count", 32'(count), 32'd1);
        chk("empty_both.data", rd_data, 32'h77);
`ifdef SYNC_FIFO_ERR_EN
        chk("empty_both.udf_err", 32'(udf_err), 32'd1);
`endif
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk_idle_empty("empty_both_done");

`ifdef SYNC_FIFO_ERR_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold.ovf_err", 32'(ovf_err), 32'd1);
            chk("hold.udf_err", 32'(udf_err), 32'd1);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr.ovf_err", 32'(ovf_err), 32'd0);
        chk("clr.udf_err", 32'(udf_err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 32'('hC0 + i);
            step();
        end
        chk("clr_race.ovf_pre", 32'(ovf_err), 32'd0);
        wr_data = 32'hEE; err_clr = 1'b1;
        step();
        wr_en = 1'b0; err_clr = 1'b0;
        chk("clr_race.ovf_err", 32'(ovf_err), 32'd1);
        chk("clr_race.count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("clr_race.data", rd_data, 32'('hC0 + i));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk_idle_empty("clr_race_done");
`endif

        // Asynchronous reset mid-burst at count=5
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 32'('hD0 + i);
            step();
        end
        wr_en = 1'b0;
        chk("pre_rst.count", 32'(count), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk_idle_empty("async_rst");
`ifdef SYNC_FIFO_ERR_EN
        chk("async_rst.ovf_err", 32'(ovf_err), 32'd0);
`endif
        step();
        rst = 1'b1;
        wr_en = 1'b1; wr_data = 32'h42;
        step();
        wr_en = 1'b0;
        chk("post_rst.count", 32'(count), 32'd1);
        chk("post_rst.data", rd_data, 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
